// File: rtl/serial_add_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_pkg : shared constants, state encoding and digit-count helper
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int ndigits(input int width);
    return width / DIGIT_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_add_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// digit_add_slice : combinational 2-bit full adder (one digit of the adder)
// Rev 1.0
// ---------------------------------------------------------------------------
module digit_add_slice
  import serial_add_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_ctrl : digit-serial adder controller, 2 bits per cycle, LSB first.
// Optional SERIAL_ADD_OVF_EN adds the out_ovf two's-complement overflow port.
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int N     = ndigits(WIDTH);
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [DIGIT_W-1:0] digit_sum;
  logic               digit_cout;

`ifdef SERIAL_ADD_OVF_EN
  logic               a_msb;
  logic               b_msb;
`endif

  // Operands shift right each digit, so the current digit is always at bit 0.
  digit_add_slice u_slice (
    .a    (op_a[DIGIT_W-1:0]),
    .b    (op_b[DIGIT_W-1:0]),
    .cin  (carry),
    .sum  (digit_sum),
    .cout (digit_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
`ifdef SERIAL_ADD_OVF_EN
      out_ovf   <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= in_b;
            carry    <= in_cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_RUN;
`ifdef SERIAL_ADD_OVF_EN
            a_msb    <= in_a[WIDTH-1];
            b_msb    <= in_b[WIDTH-1];
`endif
          end
        end

        S_RUN: begin
          op_a    <= op_a >> DIGIT_W;
          op_b    <= op_b >> DIGIT_W;
          // After N digits the first digit has reached the LSB end.
          out_sum <= (out_sum >> DIGIT_W) | (WIDTH'(digit_sum) << (WIDTH - DIGIT_W));
          carry   <= digit_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_DIGIT) begin
            out_cout  <= digit_cout;
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef SERIAL_ADD_OVF_EN
            out_ovf   <= (a_msb == b_msb) && (digit_sum[DIGIT_W-1] != a_msb);
`endif
          end
        end

        S_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
